// File: rtl/cordic_sched.sv
// cordic_sched
//   Shares one cordic engine among NREQ requesters. A round-robin arbiter
//   grants one request at a time. The accepted degree is folded into
//   -90..+90 before it goes to the engine. The cos/sin sign is restored on
//   return, and the result is delivered with the owner's id on one response
//   channel. A job whose engine never answers is aborted after TIMEOUT
//   cycles in WAIT and is reported with rsp_err=1.
//
//   State table
//     IDLE  | arbitrate; req_ready of the winner is driven combinationally
//     START | one-cycle eng_start pulse, timeout counter cleared
//     WAIT  | waiting for eng_done or timeout
//     RESP  | response held on rsp_* until rsp_ready
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester handshake, ready is one-hot
//   req_degree               packed 9-bit unsigned degrees, slot i = [9i+8:9i]
//   rsp_valid/rsp_ready      shared response handshake
//   rsp_id, rsp_cos, rsp_sin result owner and Q2.10 cos/sin
//   rsp_err                  job timed out (cos=sin=0)
//   busy                     not in IDLE
//   eng_start, eng_degree    engine start pulse and reduced signed angle
//   eng_cos, eng_sin, eng_done  engine result and one-cycle done pulse
module cordic_sched #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [9*NREQ-1:0] req_degree,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [11:0]       rsp_cos,
  output logic [11:0]       rsp_sin,
  output logic              rsp_err,
  output logic              busy,
  output logic              eng_start,
  output logic [8:0]        eng_degree,
  input  logic [11:0]       eng_cos,
  input  logic [11:0]       eng_sin,
  input  logic              eng_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt;

  // Round-robin: lowest valid index at or above rr_ptr, otherwise the
  // lowest valid index overall (the wrap-around part of the search).
  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_idx;
  logic              hi_found;
  logic [ID_W-1:0]   hi_idx;
  logic [ID_W-1:0]   lo_idx;

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    gnt_valid = 1'b0;
    // Descending scan so the last hit is the lowest index.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_valid = 1'b1;
        lo_idx    = ID_W'(k);
        if (ID_W'(k) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(k);
        end
      end
    end
    gnt_idx = hi_found ? hi_idx : lo_idx;
  end

  assign req_ready = (state == IDLE && !rst && gnt_valid)
                     ? (NREQ'(1) << gnt_idx) : '0;

  // Quadrant reduction of the winning degree.
  logic [8:0] sel_deg;
  logic [9:0] wrap_deg;
  logic [8:0] red_deg;
  logic       red_neg;

  always_comb begin
    sel_deg = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == gnt_idx) sel_deg = req_degree[9*k +: 9];
    end
    wrap_deg = (sel_deg >= 9'd360) ? ({1'b0, sel_deg} - 10'd360)
                                   : {1'b0, sel_deg};
    red_neg = 1'b0;
    red_deg = wrap_deg[8:0];
    if (wrap_deg <= 10'd90) begin
      red_deg = wrap_deg[8:0];
    end else if (wrap_deg <= 10'd269) begin
      // cos(a) = -cos(a-180), sin(a) = -sin(a-180)
      red_deg = 9'(wrap_deg - 10'd180);
      red_neg = 1'b1;
    end else begin
      red_deg = 9'(wrap_deg - 10'd360);
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      neg_q      <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_cos    <= '0;
      rsp_sin    <= '0;
      rsp_err    <= 1'b0;
      eng_start  <= 1'b0;
      eng_degree <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            id_q       <= gnt_idx;
            eng_degree <= red_deg;
            neg_q      <= red_neg;
            eng_start  <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done pulse on the timeout cycle still delivers the result.
          if (eng_done) begin
            rsp_cos   <= neg_q ? (~eng_cos + 12'd1) : eng_cos;
            rsp_sin   <= neg_q ? (~eng_sin + 12'd1) : eng_sin;
            rsp_err   <= 1'b0;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_cos   <= '0;
            rsp_sin   <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (id_q == ID_LAST) ? '0 : id_q + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
module tb_cordic_sched;

  localparam int NREQ    = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 96;
  localparam int ENG_LAT = 5;
  localparam int EXP_LAT = ENG_LAT + 2;     // accept edge to rsp_valid edge
  localparam int TO_LAT  = TIMEOUT + 1;     // START + TIMEOUT cycles in WAIT
  localparam int PERIOD  = ENG_LAT + 4 + 0; // grant-to-grant with rsp_ready high
  localparam real PI = 3.14159265358979;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [9*NREQ-1:0] req_degree = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [ID_W-1:0]   rsp_id;
  logic [11:0]       rsp_cos, rsp_sin;
  logic              rsp_err, busy, eng_start;
  logic [8:0]        eng_degree;
  logic [11:0]       eng_cos, eng_sin;
  logic              eng_done;

  always #5 clk = ~clk;

  cordic_sched #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_degree(req_degree), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err), .busy(busy),
    .eng_start(eng_start), .eng_degree(eng_degree),
    .eng_cos(eng_cos), .eng_sin(eng_sin), .eng_done(eng_done)
  );

  // ---------------- engine model ----------------
  bit         hang = 1'b0;
  logic       stray_done = 1'b0;
  logic       mdl_done;
  int         mcnt;
  logic [11:0] mc_q, ms_q;

  function automatic logic [11:0] trig(input logic [8:0] d, input bit is_sin);
    int  sd;
    real ang;
    int  v;
    sd  = int'($signed(d));
    ang = real'(sd) * PI / 180.0;
    if (is_sin) v = $rtoi($floor($sin(ang) * 1024.0 + 0.5));
    else        v = $rtoi($floor($cos(ang) * 1024.0 + 0.5));
    return 12'(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_done <= 1'b0; mcnt <= 0; eng_cos <= '0; eng_sin <= '0;
      mc_q <= '0; ms_q <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (eng_start) begin
        mcnt <= ENG_LAT;
        mc_q <= trig(eng_degree, 1'b0);
        ms_q <= trig(eng_degree, 1'b1);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !hang) begin
          mdl_done <= 1'b1; eng_cos <= mc_q; eng_sin <= ms_q;
        end
      end
    end
  end
  assign eng_done = mdl_done | stray_done;

  // ---------------- monitors ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  logic [8:0] last_eng_deg = '0;
  int grant_id[$];
  int grant_t[$];

  always @(negedge clk) begin
    if (eng_start) begin
      start_cnt++;
      last_eng_deg = eng_degree;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && (req_valid & req_ready) != '0) begin
      for (int k = 0; k < NREQ; k++)
        if (req_ready[k]) begin grant_id.push_back(k); grant_t.push_back(cyc); end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [11:0] act, input logic [11:0] exp);
    int d;
    d = int'($signed(act)) - int'($signed(exp));
    checks++;
    if (d > 2 || d < -2) begin
      errors++;
      $display("FAIL %s: got 0x%03h expected 0x%03h +-2", name, act, exp);
    end
  endtask

  // Starts at a negedge, returns at the negedge where rsp_valid is first seen.
  task automatic run_job(input int id, input logic [8:0] deg, output int lat);
    logic [NREQ-1:0] oh;
    bit got;
    oh = NREQ'(1) << id;
    req_degree[9*id +: 9] = deg;
    req_valid[id] = 1'b1;
    #1;
    check("req_ready_grant", 32'(req_ready), 32'(oh));
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    got = 1'b0;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin lat = n; got = 1'b1; break; end
    end
    check("rsp_valid_arrives", 32'(got), 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drops", 32'(rsp_valid), 32'd0);
    check("busy_after_hs", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int         id;
    logic [8:0] deg;
    logic [8:0] exp_eng;
    logic [11:0] exp_cos;
    logic [11:0] exp_sin;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat;
    int s0;
    logic [31:0] snap;
    bit done_ok;

    vecs[0]  = '{0, 9'd0,   9'h000, 12'h400, 12'h000};
    vecs[1]  = '{1, 9'd180, 9'h000, 12'hC00, 12'h000};
    vecs[2]  = '{2, 9'd270, 9'h1A6, 12'h000, 12'hC00};
    vecs[3]  = '{3, 9'd200, 9'h014, 12'hC3E, 12'hEA2};
    vecs[4]  = '{0, 9'd450, 9'h05A, 12'h000, 12'h400};
    vecs[5]  = '{1, 9'd45,  9'h02D, 12'h2D4, 12'h2D4};
    vecs[6]  = '{2, 9'd100, 9'h1B0, 12'hF4E, 12'h3F0};
    vecs[7]  = '{3, 9'd300, 9'h1C4, 12'h200, 12'hC89};
    vecs[8]  = '{0, 9'd91,  9'h1A7, 12'hFEE, 12'h400};
    vecs[9]  = '{1, 9'd269, 9'h059, 12'hFEE, 12'hC00};
    vecs[10] = '{2, 9'd359, 9'h1FF, 12'h400, 12'hFEE};
    vecs[11] = '{3, 9'd511, 9'h1E3, 12'hC80, 12'h1F0};
    vecs[12] = '{0, 9'd90,  9'h05A, 12'h000, 12'h400};
    vecs[13] = '{1, 9'd360, 9'h000, 12'h400, 12'h000};

    // reset state, with every requester asking
    req_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // directed vectors
    for (int i = 0; i < 14; i++) begin
      s0 = start_cnt;
      run_job(vecs[i].id, vecs[i].deg, lat);
      check("eng_degree", 32'(last_eng_deg), 32'(vecs[i].exp_eng));
      check("eng_start_pulses", 32'(start_cnt - s0), 32'd1);
      check("latency", 32'(lat), 32'(EXP_LAT));
      check("rsp_id", 32'(rsp_id), 32'(vecs[i].id));
      check("rsp_err", 32'(rsp_err), 32'd0);
      check_tol("rsp_cos", rsp_cos, vecs[i].exp_cos);
      check_tol("rsp_sin", rsp_sin, vecs[i].exp_sin);
      handshake();
    end

    // response held while rsp_ready low; another requester waits
    run_job(1, 9'd200, lat);
    snap = {15'd0, rsp_valid, rsp_err, rsp_id, rsp_cos[5:0], rsp_sin[5:0]};
    req_degree[18 +: 9] = 9'd0;
    req_valid[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_hold", {15'd0, rsp_valid, rsp_err, rsp_id, rsp_cos[5:0], rsp_sin[5:0]}, snap);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    check_tol("stall_cos", rsp_cos, 12'hC3E);
    req_valid[2] = 1'b0;
    handshake();

    // engine never answers
    hang = 1'b1;
    run_job(3, 9'd10, lat);
    check("to_latency", 32'(lat), 32'(TO_LAT));
    check("to_err", 32'(rsp_err), 32'd1);
    check("to_cos", 32'(rsp_cos), 32'd0);
    check("to_sin", 32'(rsp_sin), 32'd0);
    check("to_id", 32'(rsp_id), 32'd3);
    handshake();
    hang = 1'b0;
    run_job(0, 9'd0, lat);
    check("after_to_err", 32'(rsp_err), 32'd0);
    check_tol("after_to_cos", rsp_cos, 12'h400);
    handshake();

    // stray done in IDLE
    stray_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stray_done = 1'b0;
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stray_eng_start", 32'(eng_start), 32'd0);

    // reset during WAIT; rr pointer is left at 3 beforehand
    run_job(2, 9'd30, lat);
    handshake();
    req_degree[9 +: 9] = 9'd10;
    req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    req_valid[3] = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_rsp", {rsp_valid, rsp_err, 6'd0, rsp_id, rsp_cos, rsp_sin}, 32'd0);
    check("mid_rst_eng", {22'd0, eng_start, eng_degree}, 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // all requesters valid, rsp_ready high: 0,1,2,3,0 at fixed spacing
    grant_id.delete();
    grant_t.delete();
    rsp_ready = 1'b1;
    req_valid = '1;
    done_ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (grant_id.size() >= 5) begin done_ok = 1'b1; break; end
    end
    req_valid = '0;
    check("rr_grants_seen", 32'(done_ok), 32'd1);
    if (done_ok) begin
      for (int g = 0; g < 5; g++) check("rr_order", 32'(grant_id[g]), 32'(g % NREQ));
      for (int g = 0; g < 4; g++) check("rr_spacing", 32'(grant_t[g+1] - grant_t[g]), 32'(PERIOD));
    end
    done_ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) begin done_ok = 1'b1; break; end
    end
    check("rr_drain", 32'(done_ok), 32'd1);
    rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
